// File: rtl/pixel_write_arbiter_pkg.sv
// Shared widths, screen limits and the packed pixel entry used by the
// pixel write arbiter and its per-client FIFOs.
package pixel_write_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int PIX_W    = X_W + Y_W + COLOUR_W;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Drawer-side pixel write bus plus the vga_adapter plot port of the arbiter.
// master = drawers / vga consumer side, slave = the arbiter itself.
interface pixel_write_arbiter_if #(
  parameter int NUM_CLIENTS = 3
);
  import pixel_write_arbiter_pkg::*;

  logic [X_W*NUM_CLIENTS-1:0]      x_in;
  logic [Y_W*NUM_CLIENTS-1:0]      y_in;
  logic [COLOUR_W*NUM_CLIENTS-1:0] colour_in;
  logic [NUM_CLIENTS-1:0]          write_in;
  logic [X_W-1:0]                  vga_x;
  logic [Y_W-1:0]                  vga_y;
  logic [COLOUR_W-1:0]             vga_colour;
  logic                            vga_plot;
  logic [NUM_CLIENTS-1:0]          overflow;
  logic                            busy;

  modport master (
    output x_in, y_in, colour_in, write_in,
    input  vga_x, vga_y, vga_colour, vga_plot, overflow, busy
  );

  modport slave (
    input  x_in, y_in, colour_in, write_in,
    output vga_x, vga_y, vga_colour, vga_plot, overflow, busy
  );

endinterface

// File: rtl/pixel_write_arbiter_fifo.sv
// pixel_fifo: single-clock FIFO of packed pixel entries. Only pointers and
// count are reset; storage is left uninitialised.
module pixel_fifo
  import pixel_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a write when the head leaves at the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Buffers fire-and-forget pixel writes per drawer and plots them round-robin,
// one per cycle. Define PIXEL_CLIP_EN to discard off-screen writes at input.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int PTR_W       = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  pixel_write_arbiter_if.slave bus
);

  localparam int GNT_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_CLIENTS-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, in_range;
  pixel_t                 fifo_din  [NUM_CLIENTS];
  pixel_t                 fifo_dout [NUM_CLIENTS];

  logic [GNT_W-1:0]       last_grant_q, last_grant_d;
  logic [GNT_W-1:0]       search_idx;
  logic                   grant_valid;
  pixel_t                 grant_pix;

  pixel_t                 vga_pix_q, vga_pix_d;
  logic                   vga_plot_q, vga_plot_d;
  logic [NUM_CLIENTS-1:0] overflow_q, overflow_d;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    assign fifo_din[i] = {bus.x_in[X_W*i +: X_W], bus.y_in[Y_W*i +: Y_W],
                          bus.colour_in[COLOUR_W*i +: COLOUR_W]};
`ifdef PIXEL_CLIP_EN
    assign in_range[i] = on_screen(fifo_din[i].x, fifo_din[i].y);
`else
    assign in_range[i] = 1'b1;
`endif
    assign fifo_push[i] = bus.write_in[i] && in_range[i] && (!fifo_full[i] || fifo_pop[i]);

    pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (fifo_push[i]),
      .pop    (fifo_pop[i]),
      .din    (fifo_din[i]),
      .dout   (fifo_dout[i]),
      .full   (fifo_full[i]),
      .empty  (fifo_empty[i])
    );
  end

  // Search starts one past the last granted client; first non-empty wins.
  always_comb begin
    grant_valid  = 1'b0;
    grant_pix    = '0;
    fifo_pop     = '0;
    search_idx   = '0;
    last_grant_d = last_grant_q;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      search_idx = GNT_W'((int'(last_grant_q) + k) % NUM_CLIENTS);
      if (!grant_valid && !fifo_empty[search_idx]) begin
        grant_valid          = 1'b1;
        grant_pix            = fifo_dout[search_idx];
        fifo_pop[search_idx] = 1'b1;
        last_grant_d         = search_idx;
      end
    end
  end

  always_comb begin
    vga_pix_d  = vga_pix_q;
    vga_plot_d = grant_valid;
    if (grant_valid) vga_pix_d = grant_pix;
    overflow_d = overflow_q | (bus.write_in & in_range & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= GNT_W'(NUM_CLIENTS - 1);
      vga_pix_q    <= '0;
      vga_plot_q   <= 1'b0;
      overflow_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      vga_pix_q    <= vga_pix_d;
      vga_plot_q   <= vga_plot_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.vga_x      = vga_pix_q.x;
  assign bus.vga_y      = vga_pix_q.y;
  assign bus.vga_colour = vga_pix_q.colour;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (|(~fifo_empty)) || vga_plot_q;

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Consumer end of the drawer pixel-write interface (x_out, y_out, colour_out, write_out) that the life, player and obstacle drawers emit.
- Accepts fire-and-forget pixel writes from NUM_CLIENTS drawers and buffers each client in its own FIFO.
- Serialises the buffered writes round-robin into the single vga_adapter plot port, one pixel per cycle.
- Drawers never stall. Overflow is flagged, not back-pressured.

Parameters:
- NUM_CLIENTS, 3: number of drawer clients.
- FIFO_DEPTH, 8: entries per client FIFO; power of two, minimum 2.
- PTR_W, 3: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- x_in  input  8*NUM_CLIENTS  client i x coordinate in bits [8i+7:8i].
- y_in  input  7*NUM_CLIENTS  client i y coordinate in bits [7i+6:7i].
- colour_in  input  3*NUM_CLIENTS  client i colour in bits [3i+2:3i].
- write_in  input  NUM_CLIENTS  client i write strobe in bit i.
- vga_x  output  8  x coordinate to vga_adapter.
- vga_y  output  7  y coordinate to vga_adapter.
- vga_colour  output  3  colour to vga_adapter.
- vga_plot  output  1  plot strobe to vga_adapter.
- overflow  output  NUM_CLIENTS  sticky per-client drop flag.
- busy  output  1  any FIFO non-empty or vga_plot high.

Behaviour:
- Reset (async, resetn=0): all FIFOs empty; read/write pointers 0; vga_x, vga_y, vga_colour, vga_plot = 0; overflow = 0; round-robin pointer set so the next search starts at client 0.
- Push: write_in[i] sampled at a rising edge. The entry {x,y,colour} is stored if FIFO i is not full, or if FIFO i is full but is popped at the same edge.
- Drop: if FIFO i is full and not popped at that edge, the write is discarded and overflow[i] is set. overflow[i] stays set until reset.
- Pointers: wrap modulo FIFO_DEPTH. The count field is PTR_W+1 bits and ranges 0..FIFO_DEPTH.
- Arbitration, every cycle:
  - Search clients in order starting at last_grant+1, wrapping through NUM_CLIENTS-1 back to 0.
  - The first non-empty FIFO is granted and popped at the edge.
  - At the same edge its head entry is registered onto vga_x, vga_y and vga_colour, and vga_plot goes to 1.
  - If no FIFO is non-empty, vga_plot goes to 0 and vga_x, vga_y, vga_colour hold their last values.
- Latency: a write sampled at edge k into an empty system appears with vga_plot=1 after edge k+1. No combinational path from write_in to the vga_* outputs.
- Throughput: 1 pixel per cycle aggregate. With C clients continuously backlogged, each is granted once every C cycles.
- Fairness: last_grant updates only on a grant.
- Simultaneous push and pop on the same FIFO:
  - Count unchanged.
  - On an empty FIFO, pop is not possible in that cycle; the entry becomes eligible next cycle.
- Ordering: per-client order preserved. No ordering guarantee across clients.
- busy is combinational: OR of all non-empty flags OR vga_plot.
- FIFO storage has no reset requirement; only pointers and counts are reset.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined: a write with x_in >= 160 or y_in >= 120 is discarded at input. It is not stored, does not count as an overflow, and does not affect arbitration.
- Undefined: all writes are buffered and forwarded unmodified.

Decomposition:
- Shared package/include holds:
  - SCREEN_W = 160 and SCREEN_H = 120.
  - Coordinate widths X_W = 8, Y_W = 7, COLOUR_W = 3.
  - The packed pixel entry width PIX_W = 18 ({x,y,colour}).
- Sub-module pixel_fifo: single-clock FIFO with push, pop, full, empty and data ports, parameterised by depth.
  - Instantiated NUM_CLIENTS times via generate.
  - Arbiter and output register live in the top level.

Test Plan:
- Reset mid-stream: fill FIFO 0 with 5 entries, pulse resetn low between edges → vga_plot=0 and busy=0 immediately; after release, nothing plotted.
- Single write: client 1 writes (x=10, y=20, colour=3'b100) at edge k → after edge k+1, vga_plot=1 with x=10, y=20, colour=4 for exactly one cycle; overflow=0.
- Round-robin: all 3 clients write every cycle for 12 cycles → grants cycle 0,1,2,0,1,2…; every client gets 4 plots in the first 12 plot cycles; per-client order preserved.
- Overflow:
  - Client 2 writes 12 consecutive cycles while clients 0 and 1 also write every cycle → client 2 accepts ≤ FIFO_DEPTH plus its drained entries; overflow[2]=1 and stays 1.
  - A further write to a non-full FIFO is still accepted.
- Full with pop: FIFO 0 full, only client 0 active, writes each cycle → no drop; count stays 8; overflow[0]=0.
- Clip, PIXEL_CLIP_EN defined: writes (160,0) and (0,120) → no plot, overflow=0; write (159,119) → plotted. Without the macro, all three are plotted.
